// File: rtl/nand_cycle_sequencer.sv
// Raw ONFI-style NAND bus cycle sequencer: CMD/ADDR/WRDATA/RDDATA byte ops with
// programmable we/re pulse timing, optional R/B wait with timeout, and ce hold across ops.
module nand_cycle_sequencer #(
    parameter int T_WP       = 3,
    parameter int T_WH       = 2,
    parameter int T_RP       = 3,
    parameter int T_REH      = 2,
    parameter int T_WB       = 6,
    parameter int RB_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [1:0] op_type,
    input  logic [7:0] op_data,
    input  logic       op_wait_rb,
    input  logic       op_last,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       timeout,
    output logic       ce,
    output logic       cle,
    output logic       ale,
    output logic       we,
    output logic       re,
    output logic [7:0] io_write,
    output logic       io_drive_en,
    input  logic [7:0] io_in,
    input  logic       rb
);
    // state  | meaning
    // IDLE   | op_ready high, waiting for op_valid
    // SETUP  | ce/cle/ale/io set up, one cycle
    // PULSE  | we or re low for T_WP / T_RP cycles
    // HOLD   | we/re high, bus stable for T_WH / T_REH cycles
    // WB     | T_WB cycles with rb ignored
    // RBWAIT | wait for rb high, bounded by RB_TIMEOUT

    localparam int M_A   = (T_WP > T_WH) ? T_WP : T_WH;
    localparam int M_B   = (T_RP > T_REH) ? T_RP : T_REH;
    localparam int M_C   = (T_WB > RB_TIMEOUT) ? T_WB : RB_TIMEOUT;
    localparam int M_AB  = (M_A > M_B) ? M_A : M_B;
    localparam int MAX_T = (M_AB > M_C) ? M_AB : M_C;
    localparam int CW    = $clog2(MAX_T + 1);

    localparam logic [1:0] OP_CMD  = 2'b00;
    localparam logic [1:0] OP_ADDR = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b11;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WB, RBWAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    type_q;
    logic          wait_q;
    logic          last_q;
    logic          is_rd;

    assign is_rd = (type_q == OP_RD);

    // The ce register doubles as the ce-hold flag: it stays low between non-last ops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            type_q      <= OP_CMD;
            wait_q      <= 1'b0;
            last_q      <= 1'b0;
            op_ready    <= 1'b0;
            rd_data     <= 8'h00;
            rd_valid    <= 1'b0;
            timeout     <= 1'b0;
            ce          <= 1'b1;
            cle         <= 1'b0;
            ale         <= 1'b0;
            we          <= 1'b1;
            re          <= 1'b1;
            io_write    <= 8'h00;
            io_drive_en <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid && op_ready) begin
                        state    <= SETUP;
                        op_ready <= 1'b0;
                        type_q   <= op_type;
                        wait_q   <= op_wait_rb;
                        last_q   <= op_last;
                        ce       <= 1'b0;
                        cle      <= (op_type == OP_CMD);
                        ale      <= (op_type == OP_ADDR);
                        if (op_type != OP_RD) begin
                            io_drive_en <= 1'b1;
                            io_write    <= op_data;
                        end else begin
                            io_drive_en <= 1'b0;
                        end
                    end else begin
                        op_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    state <= PULSE;
                    if (is_rd) begin
                        re  <= 1'b0;
                        cnt <= CW'(T_RP - 1);
                    end else begin
                        we  <= 1'b0;
                        cnt <= CW'(T_WP - 1);
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        state <= HOLD;
                        we    <= 1'b1;
                        re    <= 1'b1;
                        if (is_rd) begin
                            rd_data <= io_in;
                            cnt     <= CW'(T_REH - 1);
                        end else begin
                            cnt <= CW'(T_WH - 1);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        cle         <= 1'b0;
                        ale         <= 1'b0;
                        io_drive_en <= 1'b0;
                        rd_valid    <= is_rd;
                        if (wait_q) begin
                            state <= WB;
                            cnt   <= CW'(T_WB - 1);
                        end else begin
                            state    <= IDLE;
                            op_ready <= 1'b1;
                            if (last_q) ce <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WB: begin
                    if (cnt == '0) begin
                        state <= RBWAIT;
                        cnt   <= CW'(RB_TIMEOUT - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RBWAIT: begin
                    if (rb) begin
                        state    <= IDLE;
                        op_ready <= 1'b1;
                        if (last_q) ce <= 1'b1;
                    end else if (cnt == '0) begin
                        state    <= IDLE;
                        op_ready <= 1'b1;
                        timeout  <= 1'b1;
                        ce       <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/nand_cycle_sequencer.md
Name: nand_cycle_sequencer

Overview:
- Sequences raw ONFI-style NAND bus cycles (command latch, address latch, data write, data read) with programmable pulse timing.
- Sits between the uart_to_nand command layer and the NAND pins and ts_buf tri-state buffer.
- Owns ce/cle/ale/we/re, io_drive_en, io_write and R/B waiting, so the upper layer only issues one byte-operation at a time over a valid/ready handshake.

Parameters:
T_WP, 3, clock cycles we held low per write-type cycle (>=1)
T_WH, 2, clock cycles we high hold after each write-type cycle (>=1)
T_RP, 3, clock cycles re held low per read cycle (>=1)
T_REH, 2, clock cycles re high hold after each read cycle (>=1)
T_WB, 6, cycles waited after an op before sampling rb (>=1)
RB_TIMEOUT, 1000000, max cycles waiting for rb high before abort

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
op_valid  input  1  operation request
op_ready  output  1  sequencer can accept an op
op_type  input  2  00 CMD, 01 ADDR, 10 WRDATA, 11 RDDATA
op_data  input  8  command/address/write byte (ignored for RDDATA)
op_wait_rb  input  1  after this op, wait T_WB then for rb high
op_last  input  1  release ce when this op completes
rd_data  output  8  byte captured in a RDDATA op
rd_valid  output  1  one-cycle strobe, rd_data valid
timeout  output  1  one-cycle strobe, R/B wait expired
ce  output  1  chip enable, active-low
cle  output  1  command latch enable, active-high
ale  output  1  address latch enable, active-high
we  output  1  write enable, active-low
re  output  1  read enable, active-low
io_write  output  8  byte driven onto io through ts_buf
io_drive_en  output  1  ts_buf enable
io_in  input  8  io bus readback
rb  input  1  ready/busy, 0 = busy

Behaviour:
- All outputs registered. Reset (rst=0 at clk edge): ce=1, cle=0, ale=0, we=1, re=1, io_write=0, io_drive_en=0, rd_data=0, rd_valid=0, timeout=0, op_ready=0 during reset, state=IDLE, ce-hold flag cleared. Reset mid-operation aborts immediately; no rd_valid or timeout is issued.
- op_ready=1 only in IDLE. An op is accepted on a cycle with op_valid&&op_ready. The op fields are latched at acceptance; later changes to the inputs are ignored.
- States: IDLE -> SETUP -> PULSE -> HOLD -> (WB -> RBWAIT) -> IDLE.
- SETUP, 1 cycle:
  - ce=0.
  - cle=1 if CMD; ale=1 if ADDR.
  - For CMD/ADDR/WRDATA: io_drive_en=1, io_write=op_data.
  - For RDDATA: io_drive_en=0.
- PULSE:
  - Write-type ops: we=0 for T_WP cycles.
  - RDDATA: re=0 for T_RP cycles; io_in is captured into rd_data on the last PULSE cycle.
  - cle/ale/io_write/io_drive_en remain stable.
- HOLD:
  - we=1 and re=1; cle/ale/io_write/io_drive_en stay stable for T_WH (write-type) or T_REH (read) cycles.
  - On the final HOLD cycle, cle, ale and io_drive_en clear on the next edge.
- rd_valid pulses for the one cycle following the last HOLD cycle of a RDDATA op.
- Op latency, no R/B wait: acceptance at cycle k means op_ready=1 again at k+2+T_WP+T_WH (write-type) or k+2+T_RP+T_REH (read).
- If op_wait_rb: after HOLD, enter WB for T_WB cycles with rb ignored, then RBWAIT.
  - RBWAIT exits to IDLE on the first cycle rb=1.
  - RBWAIT also exits after RB_TIMEOUT cycles, pulsing timeout, forcing ce=1 and clearing the ce-hold flag.
  - If rb is already 1 at the end of WB, exit after 1 RBWAIT cycle.
- ce control:
  - ce stays 0 from SETUP of the first op until completion of an op with op_last=1.
  - ce returns to 1 on entry to IDLE after that op.
  - Between non-last ops, ce stays 0 in IDLE.
- Only one op is in flight. A request arriving while busy waits; it is neither dropped nor queued.
- Counters are sized $clog2(max(param)+1). Counters never wrap: each is reloaded on state entry.

Test Plan:
- Reset, then CMD 0xFF with op_wait_rb=1, op_last=1, rb low for 20 cycles -> cle=1 and io_write=0xFF through SETUP/PULSE/HOLD; we low exactly 3 cycles; rb ignored for 6 cycles; IDLE the cycle after rb rises; ce=1 afterwards; timeout=0.
- Read-ID sequence: CMD 0x90, ADDR 0x00, 5×RDDATA with io_in model returning 0x98,0xDA,0x90,0x15,0x76, last op op_last=1 -> ale=1 only on ADDR; five rd_valid strobes with those bytes in order; io_drive_en=0 during all reads; ce low continuously until after the 5th byte.
- Back-to-back WRDATA ops with op_valid held high -> op_ready pulses once every 7 cycles (2+T_WP+T_WH); no overlap of we pulses; io_write updates only in SETUP.
- R/B timeout: override RB_TIMEOUT=50, rb stuck 0 -> timeout pulses exactly once 50 cycles into RBWAIT; ce=1; op_ready=1 the next cycle.
- Reset asserted mid-PULSE of a RDDATA op -> next edge gives all pins at reset values, rd_valid never pulses, op_ready=1 after rst deasserts.
- op_data changed during an in-flight WRDATA -> io_write keeps the latched byte through HOLD.
